// File: rtl/serial_bus_deser_if.sv
// Serial-in / word-out bus bundle for serial_bus_deser.
// The slave modport is the deserializer; the master modport is the source/consumer side.
interface serial_bus_deser_if #(
   parameter int WIDTH = 8
);
   logic             in_vld;
   logic             in_sof;
   logic             in;
   logic             in_rdy;
   logic             out_vld;
   logic             out_rdy;
   logic [WIDTH-1:0] out;
   logic             err;

   modport slave (
      input  in_vld, in_sof, in, out_rdy,
      output in_rdy, out_vld, out, err
   );

   modport master (
      output in_vld, in_sof, in, out_rdy,
      input  in_rdy, out_vld, out, err
   );
endinterface

// File: rtl/serial_bus_deser.sv
// Bit-serial (LSB first) to parallel word deserializer with one output word
// register and one word of backpressure holding in the shift register.
module serial_bus_deser #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   serial_bus_deser_if.slave   bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sync_q, sync_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             out_vld_q, out_vld_d;
   logic             err_q, err_d;

   logic             in_rdy_w;
   logic             accept;
   logic             slot_free;
   logic [IW-1:0]    idx;

   always_comb begin
      in_rdy_w  = (cnt_q != CNT_FULL);
      accept    = bus.in_vld && in_rdy_w;
      slot_free = !out_vld_q || bus.out_rdy;
      idx       = cnt_q[IW-1:0];

      cnt_d     = cnt_q;
      sync_d    = sync_q;
      sh_d      = sh_q;
      out_d     = out_q;
      err_d     = 1'b0;
      out_vld_d = out_vld_q && !bus.out_rdy;

      if (cnt_q == CNT_FULL) begin
         // Held word moves out as soon as the slot frees; no beat is taken this cycle.
         if (slot_free) begin
            out_d     = sh_q;
            out_vld_d = 1'b1;
            cnt_d     = '0;
         end
      end else if (accept) begin
         if (!sync_q || (bus.in_sof && cnt_q != '0)) begin
            // Start of a new word; only an interrupted partial word counts as an error.
            if (bus.in_sof) begin
               sync_d   = 1'b1;
               sh_d[0]  = bus.in;
               cnt_d    = CW'(1);
               err_d    = sync_q;
            end
         end else begin
            sh_d[idx] = bus.in;
            if (cnt_q == CNT_LAST) begin
               if (slot_free) begin
                  out_d     = sh_d;
                  out_vld_d = 1'b1;
                  cnt_d     = '0;
               end else begin
                  cnt_d     = CNT_FULL;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         sync_q    <= 1'b0;
         sh_q      <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         sync_q    <= sync_d;
         sh_q      <= sh_d;
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         err_q     <= err_d;
      end
   end

   assign bus.in_rdy  = in_rdy_w;
   assign bus.out_vld = out_vld_q;
   assign bus.out     = out_q;
   assign bus.err     = err_q;
endmodule

// File: tb/tb_serial_bus_deser.sv
// Randomized and directed checks of serial_bus_deser (WIDTH=4) against a
// word-level queue model of the receive rules.
module tb_serial_bus_deser;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   serial_bus_deser_if #(.WIDTH(W)) bus();

   serial_bus_deser #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: partial word as a bit queue, output slot, held word.
   bit         m_bits[$];
   bit         m_sync;
   bit         m_slot_v;
   logic [W-1:0] m_slot_d;
   bit         m_pend_v;
   logic [W-1:0] m_pend_d;
   bit         m_err;

   task automatic step(input bit r, input bit v, input bit s, input bit d, input bit ordy);
      bit free;
      logic [W-1:0] w;
      rst = r;
      bus.in_vld = v;
      bus.in_sof = s;
      bus.in = d;
      bus.out_rdy = ordy;
      if (r) begin
         m_bits = {};
         m_sync = 0;
         m_slot_v = 0;
         m_slot_d = '0;
         m_pend_v = 0;
         m_pend_d = '0;
         m_err = 0;
      end else begin
         free = !m_slot_v || ordy;
         m_err = 0;
         if (m_slot_v && ordy) m_slot_v = 0;
         if (m_pend_v) begin
            if (free) begin
               m_slot_d = m_pend_d;
               m_slot_v = 1;
               m_pend_v = 0;
            end
         end else if (v) begin
            if (!m_sync) begin
               if (s) begin
                  m_sync = 1;
                  m_bits = {d};
               end
            end else if (s && m_bits.size() != 0) begin
               m_err = 1;
               m_bits = {d};
            end else begin
               m_bits.push_back(d);
               if (m_bits.size() == W) begin
                  for (int i = 0; i < W; i++) w[i] = m_bits[i];
                  m_bits = {};
                  if (free) begin
                     m_slot_d = w;
                     m_slot_v = 1;
                  end else begin
                     m_pend_d = w;
                     m_pend_v = 1;
                  end
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      checks++; if (bus.out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%0b exp=0", bus.out_vld); end
      checks++; if (bus.out !== 4'h0) begin failures++; $display("FAIL reset_out got=%0h exp=0", bus.out); end
      checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_rdy got=%0b exp=1", bus.in_rdy); end
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      logic [3:0] b;
      b = 4'b1101;
      for (int i = 0; i < W; i++) begin
         step(0, 1, i == 0, b[i], 1);
         checks++;
         if (bus.out_vld !== (i == W - 1)) begin failures++; $display("FAIL basic_out_vld beat=%0d got=%0b exp=%0b", i, bus.out_vld, i == W - 1); end
      end
      checks++; if (bus.out !== 4'b1101) begin failures++; $display("FAIL basic_out got=%0h exp=d", bus.out); end
      step(0, 0, 0, 0, 1);
      checks++; if (bus.out_vld !== 1'b0) begin failures++; $display("FAIL basic_pulse_len got=%0b exp=0", bus.out_vld); end
      $display("test_basic out=%0h", 4'b1101);
   endtask

   task automatic test_streaming();
      logic [3:0] words[3];
      logic [3:0] wd;
      logic [3:0] got[$];
      words = '{4'h3, 4'hA, 4'h5};
      got = {};
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < W; i++) begin
            wd = words[k];
            checks++;
            if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL stream_in_rdy word=%0d beat=%0d got=%0b exp=1", k, i, bus.in_rdy); end
            step(0, 1, (k == 0 && i == 0), wd[i], 1);
            checks++;
            if (bus.out_vld !== (i == W - 1)) begin failures++; $display("FAIL stream_out_vld word=%0d beat=%0d got=%0b exp=%0b", k, i, bus.out_vld, i == W - 1); end
            if (bus.out_vld === 1'b1) got.push_back(bus.out);
         end
      end
      checks++;
      if (got.size() != 3) begin failures++; $display("FAIL stream_count got=%0d exp=3", got.size()); end
      else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (got[k] !== words[k]) begin failures++; $display("FAIL stream_word idx=%0d got=%0h exp=%0h", k, got[k], words[k]); end
         end
      end
      $display("test_streaming words=%0d", got.size());
   endtask

   task automatic test_unsynced();
      logic [3:0] b;
      logic [3:0] got[$];
      int errs;
      b = 4'b0110;
      got = {};
      errs = 0;
      step(1, 0, 0, 0, 1);
      step(0, 1, 0, 1, 1);
      step(0, 1, 0, 1, 1);
      if (bus.err === 1'b1) errs++;
      for (int i = 0; i < W + 2; i++) begin
         if (i < W) step(0, 1, i == 0, b[i], 1);
         else step(0, 0, 0, 0, 1);
         if (bus.err === 1'b1) errs++;
         if (bus.out_vld === 1'b1) got.push_back(bus.out);
      end
      checks++; if (got.size() != 1) begin failures++; $display("FAIL unsync_count got=%0d exp=1", got.size()); end
      checks++; if (got.size() > 0 && got[0] !== 4'b0110) begin failures++; $display("FAIL unsync_word got=%0h exp=6", got[0]); end
      checks++; if (errs != 0) begin failures++; $display("FAIL unsync_err got=%0d exp=0", errs); end
      $display("test_unsynced words=%0d", got.size());
   endtask

   task automatic test_early_sof();
      logic [3:0] got[$];
      got = {};
      step(1, 0, 0, 0, 1);
      step(0, 1, 1, 0, 1);
      step(0, 1, 0, 1, 1);
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL early_err_before got=%0b exp=0", bus.err); end
      step(0, 1, 1, 1, 1);
      checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL early_err_pulse got=%0b exp=1", bus.err); end
      checks++; if (bus.out_vld !== 1'b0) begin failures++; $display("FAIL early_partial_out got=%0b exp=0", bus.out_vld); end
      for (int i = 0; i < W; i++) begin
         if (i < W - 1) step(0, 1, 0, 1, 1);
         else step(0, 0, 0, 0, 1);
         if (i == 0) begin
            checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL early_err_len got=%0b exp=0", bus.err); end
         end
         if (bus.out_vld === 1'b1) got.push_back(bus.out);
      end
      checks++; if (got.size() != 1) begin failures++; $display("FAIL early_count got=%0d exp=1", got.size()); end
      checks++; if (got.size() > 0 && got[0] !== 4'hF) begin failures++; $display("FAIL early_word got=%0h exp=f", got[0]); end
      $display("test_early_sof words=%0d", got.size());
   endtask

   task automatic fill_two_words();
      logic [7:0] b;
      b = {4'h6, 4'h9};
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 2 * W; i++) step(0, 1, i == 0, b[i], 0);
   endtask

   task automatic test_backpressure();
      fill_two_words();
      checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL bp_in_rdy got=%0b exp=0", bus.in_rdy); end
      checks++; if (bus.out !== 4'h9 || bus.out_vld !== 1'b1) begin failures++; $display("FAIL bp_hold1 got=%0h/%0b exp=9/1", bus.out, bus.out_vld); end
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      checks++; if (bus.out !== 4'h9 || bus.in_rdy !== 1'b0) begin failures++; $display("FAIL bp_hold2 got=%0h/%0b exp=9/0", bus.out, bus.in_rdy); end
      step(0, 0, 0, 0, 1);
      checks++; if (bus.out !== 4'h6 || bus.out_vld !== 1'b1) begin failures++; $display("FAIL bp_second got=%0h/%0b exp=6/1", bus.out, bus.out_vld); end
      checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL bp_in_rdy_back got=%0b exp=1", bus.in_rdy); end
      step(0, 0, 0, 0, 1);
      checks++; if (bus.out_vld !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", bus.out_vld); end
      $display("test_backpressure done");
   endtask

   task automatic test_reset_pending();
      fill_two_words();
      step(1, 1, 0, 1, 0);
      checks++; if (bus.out_vld !== 1'b0 || bus.out !== 4'h0) begin failures++; $display("FAIL rstp_out got=%0h/%0b exp=0/0", bus.out, bus.out_vld); end
      checks++; if (bus.in_rdy !== 1'b1 || bus.err !== 1'b0) begin failures++; $display("FAIL rstp_flags got=%0b/%0b exp=1/0", bus.in_rdy, bus.err); end
      for (int i = 0; i < W + 1; i++) step(0, i < W, 0, 1, 1);
      checks++; if (bus.out_vld !== 1'b0 || bus.err !== 1'b0) begin failures++; $display("FAIL rstp_drop got=%0b/%0b exp=0/0", bus.out_vld, bus.err); end
      $display("test_reset_pending done");
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      step(1, 0, 0, 0, 0);
      for (int c = 0; c < 2000; c++) begin
         step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0,
              1'($urandom), $urandom_range(0, 9) < 6);
         checks++;
         if (bus.out_vld !== m_slot_v || bus.out !== m_slot_d || bus.err !== m_err || bus.in_rdy !== !m_pend_v) begin
            failures++;
            bad++;
            if (bad <= 10)
               $display("FAIL random cyc=%0d got vld=%0b out=%0h err=%0b rdy=%0b exp vld=%0b out=%0h err=%0b rdy=%0b",
                        c, bus.out_vld, bus.out, bus.err, bus.in_rdy, m_slot_v, m_slot_d, m_err, !m_pend_v);
         end
      end
      $display("test_random cycles=2000 mismatching=%0d", bad);
   endtask

   initial begin
      bus.in_vld = 0;
      bus.in_sof = 0;
      bus.in = 0;
      bus.out_rdy = 0;
      test_reset();
      test_basic();
      test_streaming();
      test_unsynced();
      test_early_sof();
      test_backpressure();
      test_reset_pending();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/serial_bus_deser.md
# serial_bus_deser

Bit-serial to parallel bus deserializer: collects single-bit beats on `in` (LSB first) and presents each completed word on bus `out[WIDTH-1:0]` under a valid/ready handshake. It is the receive-side counterpart of per-bit bus expansion: individual bit nets are regathered into an indexed bus, with bit 0 received first. It sits between a one-wire serial source and any word-wide consumer in the test and netlist-checking harnesses, and provides one word of output buffering plus one word of backpressure holding.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.

- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_vld`, input, 1: a serial beat is present on `in`.
- `in_sof`, input, 1: qualifies the beat as bit 0 of a new word; only sampled when `in_vld`.
- `in`, input, 1: serial data bit.
- `in_rdy`, output, 1: the block accepts the beat this cycle.
- `out_vld`, output, 1: `out` holds a complete word.
- `out_rdy`, input, 1: the consumer takes the word this cycle.
- `out`, output, WIDTH: assembled word; the first-received bit is `out[0]`.
- `err`, output, 1: one-cycle pulse when a partial word is discarded.

## Operation
- State: `cnt` (0..WIDTH, the number of bits held in the shift register `sh`), `sync` flag, output register plus `out_vld`.
- Beat accepted = `in_vld && in_rdy`. `in_rdy = (cnt != WIDTH)`. It is purely combinational from state and is independent of `out_rdy`.
- Unsynced (`sync=0`): accepted beats with `in_sof=0` are dropped with no state change. A beat with `in_sof=1` sets `sync=1` and stores its bit as bit 0 (`cnt` becomes 1).
- Synced: each accepted beat writes `sh[cnt]` and increments `cnt`.
- When `sync=1`, an accepted `in_sof=1` beat with `cnt` in 1..WIDTH-1 discards the partial word, pulses `err` the next cycle, and stores the new bit as bit 0 (`cnt` becomes 1). With `cnt=0`, `in_sof=1` is legal and raises no error. `in_sof` is optional mid-stream: after a word completes, the next beat is bit 0 regardless of `in_sof`.
- Output slot free = `!out_vld || out_rdy`.
- Word completion: an accepted beat with `cnt=WIDTH-1`:
  - If the slot is free, the word including the new bit loads into `out`, `out_vld` is set to 1 and `cnt` goes to 0.
  - Otherwise `cnt` goes to WIDTH (pending) and `in_rdy` drops.
- Pending (`cnt=WIDTH`): on the first cycle the slot is free, `sh` loads into `out` and `cnt` goes to 0. No beat is accepted in that cycle.
- `out_vld` clears when `out_rdy` is high and no new word loads in the same cycle.
- `out` and `out_vld` change only on a load or a drain. `out` holds its value while `out_vld=1 && !out_rdy`.
- Reset values: `cnt=0`, `sync=0`, `sh=0`, `out=0`, `out_vld=0`, `err=0`, so `in_rdy=1`.

## Timing
- Latency: last bit accepted in cycle N, slot free, gives `out_vld=1` with the word in cycle N+1.
- Throughput: one word per WIDTH cycles with `in_vld=1` and `out_rdy=1` continuously. There are no bubbles.
- Drain and load in the same cycle (`out_vld && out_rdy` while a word completes): the old word is consumed, the new word loads, and `out_vld` stays 1.
- Backpressure: the block absorbs one full word in `out` and one full word in `sh`. `in_rdy` deasserts in the cycle after the second word completes.
- `err` is registered: it is high exactly the cycle after the offending beat, and low otherwise.
- Reset mid-word or mid-hold: the next cycle shows all reset values, and partial or pending data is lost without `err`. After reset, `in_sof` is needed again to resync.

## Test plan
- Reset, then WIDTH=4, beats 1,0,1,1 (first with `in_sof=1`), `out_rdy=1` -> `out=4'b1101`, `out_vld` high for exactly 1 cycle, 1 cycle after the 4th beat.
- Streaming: 3 back-to-back words 0x3, 0xA, 0x5 (LSB first, `in_sof` on the first word only), `out_rdy=1` -> `out_vld` pulses every 4 cycles with those values, `in_rdy` constantly 1.
- Unsynced drop: after reset, 2 beats with `in_sof=0`, then `in_sof` with 0,1,1,0 -> the single word `4'b0110` is output, the dropped beats never appear, `err` stays 0.
- Early sof: 2 bits accepted, then an `in_sof` beat starting 1,1,1,1 -> `err` is high 1 cycle, the next output is `4'hF`, and no partial word is emitted.
- Backpressure: `out_rdy=0`, stream 0x9 then 0x6 -> `out=0x9` held, `in_rdy=0` after the 8th beat. Raise `out_rdy` -> 0x9 is consumed, 0x6 appears the next cycle, `in_rdy` returns to 1.
- Reset in pending state -> `out_vld=0`, `out=0`, `in_rdy=1`, `err=0`. A non-sof beat afterward is dropped.
